alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle arithmetic controller for the keypad calculator. It accepts one operation request at a time, with two 14-bit binary operands (0–9999) and a 2-bit opcode, and computes the result. Add and subtract take one compute cycle. Multiply (shift-add) and divide (restoring) run iteratively over one shared datapath. The block sits between the keypad/FSM layer, which issues `start` on an operator or equals event, and the binary-to-BCD/display path, which consumes `result` and `err`.

## Interface
Parameters:
- `WIDTH`, 14: operand and result width.
- `MAX_VALUE`, 9999: largest displayable result; anything above it is an error.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: single-cycle request pulse, sampled only in IDLE.
- `op`, in, 2: 00 add, 01 sub, 10 mul, 11 div. Sampled with `start`.
- `a`, in, WIDTH: first operand. Sampled with `start`.
- `b`, in, WIDTH: second operand. Sampled with `start`.
- `busy`, out, 1: high from the cycle after `start` is accepted through the `done` cycle.
- `done`, out, 1: single-cycle pulse; `result` and `err` are valid from this cycle onward.
- `result`, out, WIDTH: computed value, or 0 when `err`=1. Held until the next `done`.
- `err`, out, 1: overflow, negative result or divide-by-zero. Held until the next `done`.

## Operation
- States: IDLE, LOAD, ADDSUB, MUL, DIV, CHECK, DONE.
- IDLE:
  - `start`=1 latches `op`, `a` and `b` into internal registers and moves to LOAD.
  - `start` in any other state is ignored; there is no queueing.
- LOAD:
  - Clears the 2·WIDTH accumulator and the iteration counter.
  - Branches by `op`: add/sub to ADDSUB; mul to MUL; div with `b`≠0 to DIV; div with `b`=0 to CHECK with the div-zero flag set.
- ADDSUB: one cycle. Add forms a+b at WIDTH+1 bits. Sub forms a−b at WIDTH+1 bits, keeping the borrow.
- MUL:
  - WIDTH iterations, one per cycle.
  - If multiplier LSB=1, acc += multiplicand.
  - Then shift the multiplicand left and the multiplier right.
  - The full 28-bit product is kept.
- DIV:
  - WIDTH restoring iterations, one per cycle.
  - Each iteration shifts the remainder left with the next dividend bit, then trial-subtracts the divisor.
  - Quotient bit = no borrow.
  - Quotient is truncated; the remainder is discarded.
- CHECK sets `err` when any of the following hold, forcing `result`=0:
  - the value exceeds MAX_VALUE;
  - sub borrows (a<b);
  - the div-zero flag is set.
  - Otherwise the low WIDTH bits go to `result`.
- DONE: pulses `done`, updates the output registers, returns to IDLE.
- Operands above MAX_VALUE are not checked. Arithmetic is still exact; CHECK decides `err`.

## Timing
- Cycle numbering: cycle 0 is the cycle where `start` is sampled high in IDLE.
- Latency, `busy` and `done`:
  - `busy`=1 from cycle 1 until the `done` cycle inclusive; 0 in the cycle after `done`.
  - Add/sub: `done` in cycle 4.
  - Mul/div: `done` in cycle 3+WIDTH (17).
  - Div by zero: `done` in cycle 3.
- `start` in the same cycle as `done`: ignored. The next accept is possible in the cycle after `done`.
- Reset values: `busy`=0, `done`=0, `result`=0, `err`=0, state IDLE, iteration counter 0.
- Reset mid-operation: takes effect at the next edge. The in-flight operation is discarded, no `done` is produced, and outputs return to reset values.
- `rst` and `start` in the same cycle: `rst` wins; the request is dropped.

## Structure
- Shared package `calc_pkg`: opcode constants (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`), `WIDTH`, `MAX_VALUE`, and the state enumeration.
- One sub-module, `muldiv_datapath`, holds:
  - the accumulator/remainder, the shifters and the iteration counter;
  - control inputs `clr`, `step`, `mode`; status output `last`.
- `alu_sequencer` holds the FSM, the operand latches, CHECK and the output registers.

## Test plan
- `op`=add, a=1234, b=4321 → `done` in cycle 4, `result`=5555, `err`=0. Then 9999+1 → `err`=1, `result`=0.
- `op`=sub, a=5, b=9 → `err`=1, `result`=0. Then 9000−1 → 8999, `err`=0.
- `op`=mul, 99×101 → `done` in cycle 17, `result`=9999, `err`=0. Then 100×100 → `err`=1, `result`=0.
- `op`=div, 9999÷7 → `done` in cycle 17, `result`=1428. Then 5÷0 → `done` in cycle 3, `err`=1, `result`=0.
- `start` pulsed in cycle 5 of a mul → ignored; exactly one `done`, with the mul result. `result` holds its value across idle cycles.
- `rst` asserted in cycle 8 of a div → next cycle `busy`=0 and `result`=0, no `done` follows; a new add accepted right after completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the keypad calculator arithmetic path.
package calc_pkg;

    localparam int WIDTH     = 14;
    localparam int MAX_VALUE = 9999;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADDSUB,
        S_MUL,
        S_DIV,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the keypad FSM layer and the arithmetic sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, err
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared iterative datapath: shift-add multiply (mode=0) and restoring divide (mode=1).
module muldiv_datapath #(
    parameter int WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH:0]     rem;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               borrow;

    // Remainder never exceeds the divisor, so one guard bit covers the shifted value.
    always_comb begin
        rem_sh = (rem << 1) | (WIDTH + 1)'(shreg[WIDTH-1]);
        borrow = rem_sh < {1'b0, b};
        diff   = rem_sh - {1'b0, b};
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    // shreg holds the multiplier in mul mode and the dividend in div mode.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            shreg <= mode ? a : b;
            rem   <= '0;
        end else if (step) begin
            if (mode) begin
                rem   <= borrow ? rem_sh : diff;
                shreg <= shreg << 1;
                acc   <= {acc[2*WIDTH-2:0], ~borrow};
            end else begin
                if (shreg[0]) begin
                    acc <= acc + mcand;
                end
                mcand <= mcand << 1;
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle add/sub/mul/div controller with range and divide-by-zero checking.
module alu_sequencer
    import calc_pkg::state_t, calc_pkg::S_IDLE, calc_pkg::S_LOAD, calc_pkg::S_ADDSUB,
           calc_pkg::S_MUL, calc_pkg::S_DIV, calc_pkg::S_CHECK, calc_pkg::S_DONE,
           calc_pkg::OP_ADD, calc_pkg::OP_SUB, calc_pkg::OP_MUL, calc_pkg::OP_DIV;
#(
    parameter int WIDTH     = calc_pkg::WIDTH,
    parameter int MAX_VALUE = calc_pkg::MAX_VALUE
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    state_t             state, state_nx;
    logic               clr, step, mode, last;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH:0]     addsub_q;
    logic               divz_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] check_val;
    logic               check_err;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;

    function automatic logic out_of_range(input logic [2*WIDTH-1:0] v);
        return v > (2*WIDTH)'(MAX_VALUE);
    endfunction

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .step (step),
        .mode (mode),
        .a    (a_q),
        .b    (b_q),
        .acc  (acc),
        .last (last)
    );

    assign mode       = (op_q == OP_DIV);
    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                clr = 1'b1;
                case (op_q)
                    OP_ADD, OP_SUB: state_nx = S_ADDSUB;
                    OP_MUL:         state_nx = S_MUL;
                    default:        state_nx = (b_q == '0) ? S_CHECK : S_DIV;
                endcase
            end
            S_ADDSUB: state_nx = S_CHECK;
            S_MUL, S_DIV: begin
                step = 1'b1;
                if (last) state_nx = S_CHECK;
            end
            S_CHECK: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latches and intermediates carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
        end
        if (state == S_LOAD) begin
            divz_q <= (op_q == OP_DIV) && (b_q == '0);
        end
        if (state == S_ADDSUB) begin
            addsub_q <= (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q})
                                         : ({1'b0, a_q} + {1'b0, b_q});
        end
    end

    always_comb begin
        check_val = (op_q == OP_ADD || op_q == OP_SUB)
                  ? {{(WIDTH-1){1'b0}}, addsub_q} : acc;
        check_err = divz_q
                 || (op_q == OP_SUB && addsub_q[WIDTH])
                 || out_of_range(check_val);
    end

    // Outputs load on the CHECK edge so they are already valid in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (state == S_CHECK) begin
            err_q    <= check_err;
            result_q <= check_err ? '0 : check_val[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_sequencer_if #(.WIDTH(14)) bus();

    alu_sequencer #(.WIDTH(14), .MAX_VALUE(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input int av, input int bv,
                         input int exp_r, input int exp_e, input int exp_lat);
        int  cyc;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = 14'(av);
        bus.b     = 14'(bv);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy1"}, bus.busy, 1);
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_lat"}, seen ? cyc : -1, exp_lat);
        check({tag, "_res"}, bus.result, exp_r);
        check({tag, "_err"}, bus.err, exp_e);
        check({tag, "_busyd"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_busy0"}, bus.busy, 0);
        check({tag, "_hold"}, bus.result, exp_r);
    endtask

    initial begin
        int ndone;
        int done_cyc;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_err", bus.err, 0);

        // rst and start together: request dropped
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 14'd1;
        bus.b     = 14'd1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        @(negedge clk);
        check("rst_start_busy2", bus.busy, 0);

        do_op("add",   2'b00, 1234, 4321, 5555, 0, 4);
        do_op("addov", 2'b00, 9999, 1,    0,    1, 4);
        do_op("subneg",2'b01, 5,    9,    0,    1, 4);
        do_op("sub",   2'b01, 9000, 1,    8999, 0, 4);
        do_op("mul",   2'b10, 99,   101,  9999, 0, 17);
        do_op("mulov", 2'b10, 100,  100,  0,    1, 17);
        do_op("div",   2'b11, 9999, 7,    1428, 0, 17);
        do_op("divz",  2'b11, 5,    0,    0,    1, 3);
        do_op("div2",  2'b11, 100,  3,    33,   0, 17);

        // start pulsed in cycle 5 of a mul is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 14'd99;
        bus.b     = 14'd101;
        ndone     = 0;
        done_cyc  = -1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 14'd1;
                bus.b     = 14'd1;
            end
            if (bus.done) begin
                ndone++;
                done_cyc = c;
                check("ign_res", bus.result, 9999);
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", done_cyc, 17);
        repeat (5) @(negedge clk);
        check("ign_hold", bus.result, 9999);
        check("ign_idle", bus.busy, 0);

        // reset in cycle 8 of a div
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 14'd9999;
        bus.b     = 14'd7;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("mid_busy_pre", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", bus.busy, 0);
        check("mid_result", bus.result, 0);
        check("mid_err", bus.err, 0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("mid_nodone", ndone, 0);
        do_op("post", 2'b00, 2, 3, 5, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
